memory_round_controller: RTL and testbench
==========================================

Name: memory_round_controller

Overview:
Sequences one round of the memorization game. It shows a target digit sequence one digit at a time, then collects keypad entries from keyboard_decoder and compares each one against the target. It reports pass, fail or timeout when the round ends. It sits between the keypad decoder (key strobe/code) and the display/score logic.

Parameters:
MAX_LEN, 8, maximum sequence length in digits (2..15)
SHOW_CYCLES, 25000000, clocks each digit is shown (>=1)
GAP_CYCLES, 5000000, blank clocks after each shown digit (>=1)
TIMEOUT_CYCLES, 250000000, max clocks between round entry/last accepted key and next key (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a round; honoured only in IDLE
round_len  input  4  requested length, sampled with start
target_seq  input  4*MAX_LEN  digit i at [4i+3:4i]; digit 0 shown/entered first; sampled with start
key_value  input  4  key code from decoder
key_ready  input  1  one-cycle strobe, key_value valid
show_digit  output  4  digit currently displayed
show_valid  output  1  high while show_digit is to be displayed
entry_count  output  4  correct digits entered so far this round
busy  output  1  high in every state except IDLE
pass  output  1  one-cycle pulse, full sequence entered correctly
fail  output  1  one-cycle pulse, wrong key or timeout
timeout  output  1  one-cycle pulse coincident with fail when cause is timeout
state  output  3  IDLE=0, SHOW=1, GAP=2, INPUT=3, DONE=4

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low. Reset clears all registers and outputs to 0, state=IDLE.
- All outputs are registered.
- IDLE:
  - start=1 latches target_seq and the effective length, then goes to SHOW next cycle.
  - Effective length: round_len=0 becomes 1; round_len>MAX_LEN becomes MAX_LEN.
  - Also clears entry_count, the digit index and the cycle counter.
- SHOW:
  - show_valid=1 and show_digit=latched digit[index] for exactly SHOW_CYCLES cycles, then GAP.
- GAP:
  - show_valid=0 for exactly GAP_CYCLES cycles.
  - show_digit holds its last value.
  - Then, if index < len-1: index++ and go to SHOW. Otherwise go to INPUT, with the timeout counter at 0.
- key_ready in IDLE, SHOW, GAP or DONE is ignored and has no side effects.
- INPUT:
  - The timeout counter increments every cycle without key_ready.
  - key_ready with key_value == digit[entry_count]:
    - entry_count++ and the timeout counter resets.
    - If the new count equals len, pass pulses on the next cycle and the state goes to DONE.
  - key_ready with a mismatch: fail pulses on the next cycle, state goes to DONE, and entry_count holds.
  - Counter reaching TIMEOUT_CYCLES-1 with no key_ready: fail and timeout pulse on the next cycle, state goes to DONE.
  - key_ready in the same cycle as the timeout threshold: the key wins and the timeout is suppressed.
- DONE:
  - Lasts one cycle, then IDLE.
  - pass/fail/timeout are high only during that DONE cycle.
  - entry_count holds until the next start.
- start outside IDLE is ignored, including in DONE.
- start in the same cycle the controller returns to IDLE is not lost: IDLE samples start on its first cycle.
- Reset asserted mid-round aborts immediately with no pass/fail pulse.
- Counter widths are sized for the largest of SHOW_CYCLES, GAP_CYCLES and TIMEOUT_CYCLES, with no wrap inside any phase.

Test Plan (SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, MAX_LEN=8):
- Show timing: start with round_len=3, target_seq low digits 1,5,9.
  - show_valid high 4 cycles each with show_digit 1, then 5, then 9, separated by 2-cycle gaps.
  - INPUT is reached 18 cycles after SHOW entry.
- Correct entry: keys 1, 5, 9 on separate strobes in INPUT.
  - entry_count goes 1, 2, 3.
  - pass pulses 1 cycle after the third strobe; fail stays 0; state 4 then 0.
- Wrong key: target 1,5,9, keys 1 then 4.
  - fail pulses, timeout=0, entry_count=1, pass never asserted.
- Timeout:
  - No key for 20 cycles after INPUT entry: fail and timeout pulse together.
  - A key at cycle 19 restarts the count instead.
- Ignored inputs:
  - key_ready during SHOW/GAP leaves entry_count at 0.
  - start during INPUT leaves state unchanged.
  - round_len=0 shows 1 digit; round_len=12 shows 8 digits.
- Reset mid-round: drive rst low during GAP of digit 2.
  - All outputs go to 0 immediately, state=0, no pass/fail pulse.
  - A fresh start then runs a normal round.

Source files
------------

// File: rtl/memory_round_controller.sv
// One round of the memorization game: show the target digits one at a time,
// then collect keypad entries and report pass, fail or timeout.
module memory_round_controller #(
   parameter int MAX_LEN        = 8,
   parameter int SHOW_CYCLES    = 25000000,
   parameter int GAP_CYCLES     = 5000000,
   parameter int TIMEOUT_CYCLES = 250000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [3:0]             round_len,
   input  logic [4*MAX_LEN-1:0]   target_seq,
   input  logic [3:0]             key_value,
   input  logic                   key_ready,
   output logic [3:0]             show_digit,
   output logic                   show_valid,
   output logic [3:0]             entry_count,
   output logic                   busy,
   output logic                   pass,
   output logic                   fail,
   output logic                   timeout,
   output logic [2:0]             state
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SHOW  = 3'd1;
   localparam logic [2:0] GAP   = 3'd2;
   localparam logic [2:0] INPUT = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam int CMAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int CMAX    = (CMAX_SG > TIMEOUT_CYCLES) ? CMAX_SG : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CMAX + 1);

   localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    MAXL      = 4'(MAX_LEN);

   logic [2:0]           state_q, state_d;
   logic [3:0]           len_q, len_d;
   logic [4*MAX_LEN-1:0] seq_q, seq_d;
   logic [3:0]           idx_q, idx_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           entry_q, entry_d;
   logic [3:0]           digit_q, digit_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 pass_q, pass_d;
   logic                 fail_q, fail_d;
   logic                 tmo_q, tmo_d;
   logic [4*MAX_LEN-1:0] show_sh, ent_sh;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      seq_d   = seq_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      entry_d = entry_q;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      tmo_d   = 1'b0;
      ent_sh  = seq_q >> {entry_q, 2'b00};

      case (state_q)
         IDLE: begin
            if (start) begin
               seq_d   = target_seq;
               if (round_len == 4'd0)     len_d = 4'd1;
               else if (round_len > MAXL) len_d = MAXL;
               else                       len_d = round_len;
               idx_d   = 4'd0;
               cnt_d   = '0;
               entry_d = 4'd0;
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d   = '0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (4'(idx_q + 4'd1) < len_q) begin
                  idx_d   = idx_q + 4'd1;
                  state_d = SHOW;
               end else begin
                  state_d = INPUT;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         INPUT: begin
            // A key in the threshold cycle takes priority over the timeout.
            if (key_ready) begin
               if (key_value == ent_sh[3:0]) begin
                  entry_d = entry_q + 4'd1;
                  cnt_d   = '0;
                  if (4'(entry_q + 4'd1) == len_q) begin
                     state_d = DONE;
                     pass_d  = 1'b1;
                  end
               end else begin
                  state_d = DONE;
                  fail_d  = 1'b1;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = DONE;
               fail_d  = 1'b1;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Display outputs are derived from next state so they register in step.
      show_sh = seq_d >> {idx_d, 2'b00};
      valid_d = (state_d == SHOW);
      digit_d = (state_d == SHOW) ? show_sh[3:0] : digit_q;
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         seq_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         entry_q <= '0;
         digit_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         seq_q   <= seq_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         entry_q <= entry_d;
         digit_q <= digit_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         tmo_q   <= tmo_d;
      end
   end

   assign state       = state_q;
   assign show_digit  = digit_q;
   assign show_valid  = valid_q;
   assign entry_count = entry_q;
   assign busy        = busy_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = tmo_q;

endmodule

// File: tb/tb_memory_round_controller.sv
// Scoreboard bench for memory_round_controller: stimulus pushes expected shown
// digits and round results; a negedge monitor pops and compares them.
module tb_memory_round_controller;

   localparam int ML = 8;
   localparam int SC = 4;
   localparam int GC = 2;
   localparam int TC = 20;

   logic          clk, rst, start, key_ready;
   logic [3:0]    round_len, key_value;
   logic [4*ML-1:0] target_seq;
   logic [3:0]    show_digit, entry_count;
   logic          show_valid, busy, pass, fail, timeout;
   logic [2:0]    state;

   memory_round_controller #(
      .MAX_LEN(ML), .SHOW_CYCLES(SC), .GAP_CYCLES(GAP_C()), .TIMEOUT_CYCLES(TC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .round_len(round_len),
      .target_seq(target_seq), .key_value(key_value), .key_ready(key_ready),
      .show_digit(show_digit), .show_valid(show_valid), .entry_count(entry_count),
      .busy(busy), .pass(pass), .fail(fail), .timeout(timeout), .state(state)
   );

   function automatic int GAP_C();
      return GC;
   endfunction

   typedef struct {
      bit         is_done;
      logic [3:0] digit;
      bit         p, f, t;
      logic [3:0] entry;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_shows(input logic [31:0] seq, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e = '{1'b0, 4'(seq >> (4*i)), 1'b0, 1'b0, 1'b0, 4'd0};
         q.push_back(e);
      end
   endtask

   task automatic push_done(input bit p, input bit f, input bit t, input logic [3:0] en);
      exp_t e;
      e = '{1'b1, 4'd0, p, f, t, en};
      q.push_back(e);
   endtask

   // All stimulus tasks are entered and left 1 time unit after a rising edge.
   task automatic start_round(input logic [3:0] l, input logic [31:0] s);
      start = 1'b1; round_len = l; target_seq = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic press(input logic [3:0] k);
      key_ready = 1'b1; key_value = k;
      @(posedge clk); #1;
      key_ready = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output int n);
      n = 0;
      while (state != s && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (state != s) check("wait_state_budget", {29'd0, state}, {29'd0, s});
   endtask

   task automatic check_all_zero(input string name);
      check(name, {show_digit, show_valid, entry_count, busy, pass, fail, timeout, state}, 0);
   endtask

   // Monitor: show runs and DONE cycles are matched against the scoreboard.
   initial begin : monitor
      bit prev_sv;
      int run;
      logic [3:0] run_dig;
      exp_t e;
      prev_sv = 1'b0; run = 0; run_dig = 4'd0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_sv = 1'b0; run = 0;
         end else begin
            if (show_valid) begin
               if (!prev_sv) begin
                  run = 1; run_dig = show_digit;
               end else begin
                  run++;
                  if (show_digit != run_dig) check("show_digit_stable", show_digit, run_dig);
               end
            end else if (prev_sv) begin
               if (q.size() == 0) check("sb_unexpected_show", 0, 1);
               else begin
                  e = q.pop_front();
                  check("sb_kind_show", e.is_done, 0);
                  check("show_digit", run_dig, e.digit);
                  check("show_len", run, SC);
               end
            end
            prev_sv = show_valid;
            if (state == 3'd4) begin
               if (q.size() == 0) check("sb_unexpected_done", 0, 1);
               else begin
                  e = q.pop_front();
                  check("sb_kind_done", e.is_done, 1);
                  check("done_pft", {pass, fail, timeout}, {e.p, e.f, e.t});
                  check("done_entry", entry_count, e.entry);
               end
            end else if (pass || fail || timeout) begin
               check("stray_pulse", {pass, fail, timeout}, 0);
            end
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_value = 4'd0;
      round_len = 4'd0; target_seq = '0;
      #2 rst = 1'b0;
      #1 check_all_zero("reset_state");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      // Show timing, keys ignored while showing, correct entry.
      push_shows(32'h951, 3);
      start_round(4'd3, 32'h951);
      check("busy_show", {busy, state}, {1'b1, 3'd1});
      n = 0;
      while (state != 3'd3 && n < 40) begin
         @(posedge clk); #1;
         n++;
         key_ready = (n == 3 || n == 9 || n == 16);
         key_value = 4'd1;
      end
      key_ready = 1'b0;
      check("show_to_input_cycles", n, 18);
      check("keys_ignored_in_show", entry_count, 0);
      press(4'd1); check("entry_1", entry_count, 1);
      press(4'd5); check("entry_2", entry_count, 2);
      push_done(1'b1, 1'b0, 1'b0, 4'd3);
      press(4'd9); check("pass_state_done", state, 4);
      @(posedge clk); #1;
      check("back_to_idle", {busy, state}, 0);

      // Wrong key, with an ignored start while in INPUT.
      push_shows(32'h951, 3);
      start_round(4'd3, 32'h951);
      wait_state(3'd3, 40, n);
      start_round(4'd5, 32'h1234);
      check("start_in_input_ignored", state, 3);
      press(4'd1); check("wrong_entry_1", entry_count, 1);
      push_done(1'b0, 1'b1, 1'b0, 4'd1);
      press(4'd4); check("wrong_state_done", state, 4);
      @(posedge clk); #1;
      check("wrong_idle", state, 0);

      // Plain timeout.
      push_shows(32'h21, 2);
      start_round(4'd2, 32'h21);
      wait_state(3'd3, 40, n);
      push_done(1'b0, 1'b1, 1'b1, 4'd0);
      wait_state(3'd4, 40, n);
      check("timeout_cycles", n, 20);
      @(posedge clk); #1;

      // Key in the threshold cycle restarts the count.
      push_shows(32'h21, 2);
      start_round(4'd2, 32'h21);
      wait_state(3'd3, 40, n);
      repeat (19) @(posedge clk);
      #1;
      press(4'd1);
      check("late_key_state", {state, entry_count}, {3'd3, 4'd1});
      push_done(1'b0, 1'b1, 1'b1, 4'd1);
      wait_state(3'd4, 40, n);
      check("timeout_restart_cycles", n, 20);
      @(posedge clk); #1;

      // Length clamping: 0 -> 1 digit, 12 -> 8 digits.
      push_shows(32'h7, 1);
      start_round(4'd0, 32'h7);
      wait_state(3'd3, 40, n);
      check("len0_cycles", n, 6);
      push_done(1'b1, 1'b0, 1'b0, 4'd1);
      press(4'd7);
      @(posedge clk); #1;
      push_shows(32'h87654321, 8);
      start_round(4'd12, 32'h87654321);
      wait_state(3'd3, 80, n);
      check("len12_cycles", n, 48);
      push_done(1'b0, 1'b1, 1'b0, 4'd0);
      press(4'd0);
      @(posedge clk); #1;

      // Reset in the gap after digit 2, then a fresh round.
      push_shows(32'h951, 2);
      start_round(4'd3, 32'h951);
      repeat (11) @(posedge clk);
      #1;
      check("gap2_state", state, 2);
      #2 rst = 1'b0;
      #1 check_all_zero("reset_mid_round");
      @(posedge clk); @(posedge clk); #1;
      check_all_zero("reset_held");
      rst = 1'b1;
      push_shows(32'h3, 1);
      start_round(4'd1, 32'h3);
      wait_state(3'd3, 40, n);
      check("fresh_cycles", n, 6);
      push_done(1'b1, 1'b0, 1'b0, 4'd1);
      press(4'd3);
      @(posedge clk); @(posedge clk); #1;
      check("sb_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
